atree_accumulator: RTL
======================

Name: atree_accumulator

Overview:
- Downstream stage of an adder-tree level; consumes one tree sum per accepted beat and accumulates the partial sums of a group into a wide register.
- A group is a run of beats ending with in_last. One result per group is presented on a valid/ready output.
- Sits between the final adder-tree level and the result writeback logic. It lets a reduction wider than the tree be split into several passes.

Parameters:
- IN_WIDTH, 33, width of each tree sum (unsigned), i.e. the tree-level input width + 1
- ACC_WIDTH, 48, accumulator and result width; must be >= IN_WIDTH
- CNT_WIDTH, 8, width of the per-group beat counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  IN_WIDTH  unsigned partial sum from adder tree
- in_last  input  1  beat is final partial of current group
- out_valid  output  1  out_data/out_count/out_ovf valid
- out_ready  input  1  downstream accepts result
- out_data  output  ACC_WIDTH  accumulated group sum
- out_count  output  CNT_WIDTH  beats in group, saturating at 2^CNT_WIDTH-1
- out_ovf  output  1  accumulator overflowed at least once in this group

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=0, count=0, ovf=0, out_valid=0, out_data=0, out_count=0, out_ovf=0. in_ready=1 once reset is deasserted. A partially accumulated group is discarded with no output.
- States:
  - IDLE: no group open.
  - ACCUM: group open, acc holds the running sum.
- The output register is independent of state: out_valid is set when a group closes and cleared when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational). A beat is accepted when in_valid && in_ready.
- Accept in IDLE: acc = zero-extended in_data, count=1, ovf=0. If in_last=0, go to ACCUM; otherwise close the group immediately (single-beat group).
- Accept in ACCUM: acc = acc + zero-extended in_data, count = count+1 (saturating), ovf |= carry-out of the ACC_WIDTH-bit add. If in_last=1, close the group.
- Close group: on the next edge out_valid=1 and out_data/out_count/out_ovf take the final values including this beat; state goes to IDLE.
- Latency: out_valid is asserted on the cycle after the in_last beat is accepted.
- Output payload is stable while out_valid && !out_ready.
- Simultaneous output handshake and input accept in the same cycle is legal:
  - The old result retires.
  - The new beat is processed normally.
  - If that beat closes a group, out_valid stays 1 with the new payload.
  - Sustained throughput is one beat per cycle.
- Back-pressure: while out_valid=1 and out_ready=0, in_ready=0. No input is lost and acc is frozen.
- No beats in flight: out_valid never rises without an accepted in_last.
- Arithmetic: unsigned, modulo 2^ACC_WIDTH by default. Carry-out sets the sticky ovf for the current group only; ovf is cleared when the next group starts.
- in_data and in_last are ignored when not accepted.

Optional Feature:
- Macro ATREE_ACC_SATURATE_EN.
- Defined: on carry-out, acc clamps to all-ones (2^ACC_WIDTH-1) and stays clamped for the rest of the group; ovf is still set.
- Undefined: acc wraps modulo 2^ACC_WIDTH; ovf is set.
- All other behaviour is identical.

Test Plan:
- Reset mid-group: 2 beats (5, 7, in_last=0), assert rst, release, send 3 with in_last=1 -> single result out_data=3, out_count=1, out_ovf=0. No output for the discarded group.
- Basic group: beats 10, 20, 30 (last on 30), out_ready=1 -> out_valid one cycle after the third accept, out_data=60, out_count=3, out_ovf=0, then out_valid=0.
- Back-to-back single-beat groups: in_valid=1, in_last=1 every cycle with data 1,2,3,4, out_ready=1 -> in_ready held 1, outputs 1,2,3,4 on consecutive cycles.
- Back-pressure: group 4+4 closes, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data=8 stable. When out_ready=1, the pending beat is accepted in the same cycle.
- Overflow with ACC_WIDTH=IN_WIDTH=8: beats 200, 100 (last) -> without the macro out_data=44, out_ovf=1; with ATREE_ACC_SATURATE_EN out_data=255, out_ovf=1. The following group 1 (last) gives out_data=1, out_ovf=0.
- Count saturation with CNT_WIDTH=2: 5 beats of 1 -> out_data=5, out_count=3.

Source files
------------

// File: rtl/atree_accumulator.sv
// Accumulates adder-tree partial sums per group (closed by in_last) and presents one result per group.
// Build option: define ATREE_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module atree_accumulator #(
    parameter int IN_WIDTH  = 33,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_ovf_q, out_ovf_d;

    logic                 accept;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH:0]   sum_wide;

    // Overflow policy for a carry out of the ACC_WIDTH-bit add. Once clamped at all-ones,
    // any further non-zero beat carries again, so the clamp holds for the rest of the group.
    function automatic logic [ACC_WIDTH-1:0] acc_resolve(input logic [ACC_WIDTH:0] s);
`ifdef ATREE_ACC_SATURATE_EN
        if (s[ACC_WIDTH]) begin
            return {ACC_WIDTH{1'b1}};
        end
        return s[ACC_WIDTH-1:0];
`else
        return s[ACC_WIDTH-1:0];
`endif
    endfunction

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_WIDTH'(1);
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_ext   = ACC_WIDTH'(in_data);
    assign sum_wide = {1'b0, acc_q} + {1'b0, in_ext};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                IDLE: begin
                    acc_d = in_ext;
                    cnt_d = CNT_WIDTH'(1);
                    ovf_d = 1'b0;
                end
                ACCUM: begin
                    acc_d = acc_resolve(sum_wide);
                    cnt_d = cnt_inc(cnt_q);
                    ovf_d = ovf_q | sum_wide[ACC_WIDTH];
                end
                default: begin
                    acc_d = in_ext;
                    cnt_d = CNT_WIDTH'(1);
                    ovf_d = 1'b0;
                end
            endcase

            // A closing beat may coincide with retiring the previous result; the new payload wins.
            if (in_last) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                out_data_d  = acc_d;
                out_count_d = cnt_d;
                out_ovf_d   = ovf_d;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
